// File: rtl/prm_edge_scan_ctrl.sv
// -----------------------------------------------------------------------------
// prm_edge_scan_ctrl
//
// Sequencer for the PRM edge obstacle-check bank. A request latches a 15-bit
// obstacle vector. The block then sweeps edge indices 0..NUM_EDGES-1 through
// the external checker mux and collects the returned edge_mask bits into a
// small result FIFO. Results stream out under res_valid/res_ready. Issue is
// credit-limited, so the FIFO can never overflow. A one-cycle done pulse
// reports completion together with the blocked-edge count.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   scan request handshake (ready only in IDLE)
//   req_obs[14:0]         obstacle vector (bit 0 = A ... bit 14 = O)
//   abort                 cancel the running scan (SCAN/DRAIN only)
//   chk_valid/chk_idx     issue strobe and edge index to the checker bank
//   chk_obs[14:0]         latched obstacle vector, stable for the whole scan
//   chk_mask              edge_mask for the edge issued CHK_LAT cycles earlier
//   res_valid/res_ready   result stream handshake
//   res_idx/res_mask      result edge index and blocked flag
//   done                  one-cycle scan-complete pulse
//   blk_cnt               blocked edges in the last completed scan
//
// Configuration macro: PRM_BLK_CNT_EN
//   defined   -> the blocked-edge counter is built and reported on blk_cnt
//   undefined -> no counter logic, blk_cnt is tied to zero
// -----------------------------------------------------------------------------
module prm_edge_scan_ctrl #(
    parameter int NUM_EDGES  = 1024,
    parameter int IDX_W      = 10,
    parameter int CHK_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [14:0]      req_obs,
    input  logic             abort,
    output logic             chk_valid,
    output logic [IDX_W-1:0] chk_idx,
    output logic [14:0]      chk_obs,
    input  logic             chk_mask,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDX_W-1:0] res_idx,
    output logic             res_mask,
    output logic             done,
    output logic [IDX_W:0]   blk_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(CHK_LAT + 2);
    localparam int SUM_W = $clog2(FIFO_DEPTH + CHK_LAT + 3) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EDGES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_req_ready;
    logic                r_chk_valid;
    logic [IDX_W-1:0]    r_chk_idx;
    logic [14:0]         r_chk_obs;
    logic [IDX_W-1:0]    r_next_idx;
    logic                r_done;

    // Inflight pipe: stage k holds the issue made k+1 cycles ago.
    logic [CHK_LAT-1:0]  r_pipe_v;
    logic [IDX_W-1:0]    r_pipe_idx [CHK_LAT];

    // Result FIFO, entry = {idx, mask}
    logic [IDX_W:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_abort;
    logic                w_accept;
    logic                w_push;
    logic [IDX_W-1:0]    w_push_idx;
    logic                w_pop;
    logic [INF_W-1:0]    w_inflight;
    logic [SUM_W-1:0]    w_used;
    logic [SUM_W-1:0]    w_limit;
    logic                w_can_issue;
    logic                w_to_done;

    assign w_abort    = abort && ((r_state == S_SCAN) || (r_state == S_DRAIN));
    assign w_accept   = (r_state == S_IDLE) && req_valid;
    assign w_push     = r_pipe_v[CHK_LAT-1];
    assign w_push_idx = r_pipe_idx[CHK_LAT-1];
    assign w_pop      = (r_count != {CNT_W{1'b0}}) && res_ready;

    // Outstanding work: the issue register plus every live pipe stage.
    always_comb begin
        w_inflight = INF_W'(r_chk_valid);
        for (int k = 0; k < CHK_LAT; k++) begin
            w_inflight = w_inflight + INF_W'(r_pipe_v[k]);
        end
    end

    // Credit check. Every issued edge reserves a FIFO slot until it is popped;
    // a pop happening on this same edge frees its slot in time for a new issue,
    // which is what sustains one issue per cycle while the consumer keeps up.
    assign w_used      = SUM_W'(r_count) + SUM_W'(w_inflight);
    assign w_limit     = SUM_W'(FIFO_DEPTH) + SUM_W'(w_pop);
    assign w_can_issue = (w_used < w_limit);

    assign w_to_done = (r_state == S_DRAIN) && !abort &&
                       (w_inflight == {INF_W{1'b0}}) && (r_count == {CNT_W{1'b0}});

    // Scan FSM with registered handshake, issue and completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_chk_valid <= 1'b0;
            r_chk_idx   <= {IDX_W{1'b0}};
            r_chk_obs   <= 15'd0;
            r_next_idx  <= {IDX_W{1'b0}};
            r_done      <= 1'b0;
        end else begin
            r_chk_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_chk_obs   <= req_obs;
                        r_next_idx  <= {IDX_W{1'b0}};
                        r_req_ready <= 1'b0;
                        r_state     <= S_SCAN;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (abort) begin
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (w_can_issue) begin
                        r_chk_valid <= 1'b1;
                        r_chk_idx   <= r_next_idx;
                        r_next_idx  <= r_next_idx + {{(IDX_W-1){1'b0}}, 1'b1};
                        if (r_next_idx == LAST_IDX) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end else begin
                        r_state <= S_SCAN;
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (w_to_done) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // Inflight valid/index shift register; abort kills every pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_v <= {CHK_LAT{1'b0}};
            for (int k = 0; k < CHK_LAT; k++) begin
                r_pipe_idx[k] <= {IDX_W{1'b0}};
            end
        end else if (w_abort) begin
            r_pipe_v <= {CHK_LAT{1'b0}};
        end else begin
            r_pipe_v[0]   <= r_chk_valid;
            r_pipe_idx[0] <= r_chk_idx;
            for (int k = 1; k < CHK_LAT; k++) begin
                r_pipe_v[k]   <= r_pipe_v[k-1];
                r_pipe_idx[k] <= r_pipe_idx[k-1];
            end
        end
    end

    // Result FIFO: pipe tail pushes, consumer pops; abort empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            for (int k = 0; k < FIFO_DEPTH; k++) begin
                r_mem[k] <= {(IDX_W+1){1'b0}};
            end
        end else if (w_abort) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_push_idx, chk_mask};
                r_wr_ptr        <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (!w_push && w_pop) begin
                r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_count <= r_count;
            end
        end
    end

`ifdef PRM_BLK_CNT_EN
    logic [IDX_W:0] r_blk_run;
    logic [IDX_W:0] r_blk_cnt;

    // Running blocked count for the current scan; published only on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_run <= {(IDX_W+1){1'b0}};
            r_blk_cnt <= {(IDX_W+1){1'b0}};
        end else begin
            if (w_accept) begin
                r_blk_run <= {(IDX_W+1){1'b0}};
            end else if (w_push && chk_mask) begin
                r_blk_run <= r_blk_run + {{IDX_W{1'b0}}, 1'b1};
            end else begin
                r_blk_run <= r_blk_run;
            end
            if (w_to_done) begin
                r_blk_cnt <= r_blk_run;
            end else begin
                r_blk_cnt <= r_blk_cnt;
            end
        end
    end

    assign blk_cnt = r_blk_cnt;
`else
    assign blk_cnt = {(IDX_W+1){1'b0}};
`endif

    assign req_ready = r_req_ready;
    assign chk_valid = r_chk_valid;
    assign chk_idx   = r_chk_idx;
    assign chk_obs   = r_chk_obs;
    assign res_valid = (r_count != {CNT_W{1'b0}});
    assign res_idx   = r_mem[r_rd_ptr][IDX_W:1];
    assign res_mask  = r_mem[r_rd_ptr][0];
    assign done      = r_done;

endmodule

// File: tb/tb_prm_edge_scan_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for prm_edge_scan_ctrl (NUM_EDGES=8, CHK_LAT=2,
// FIFO_DEPTH=4). A small checker model answers each issue with a mask after
// CHK_LAT cycles; each issue pushes the expected {idx, mask} onto a scoreboard
// queue, which is popped and compared on each result transfer.
// -----------------------------------------------------------------------------
module tb_prm_edge_scan_ctrl;

    localparam int NUM_EDGES  = 8;
    localparam int IDX_W      = 3;
    localparam int CHK_LAT    = 2;
    localparam int FIFO_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [14:0]      req_obs;
    logic             abort;
    logic             chk_valid;
    logic [IDX_W-1:0] chk_idx;
    logic [14:0]      chk_obs;
    logic             chk_mask;
    logic             res_valid;
    logic             res_ready;
    logic [IDX_W-1:0] res_idx;
    logic             res_mask;
    logic             done;
    logic [IDX_W:0]   blk_cnt;

    prm_edge_scan_ctrl #(
        .NUM_EDGES (NUM_EDGES),
        .IDX_W     (IDX_W),
        .CHK_LAT   (CHK_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_obs  (req_obs),
        .abort    (abort),
        .chk_valid(chk_valid),
        .chk_idx  (chk_idx),
        .chk_obs  (chk_obs),
        .chk_mask (chk_mask),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_idx  (res_idx),
        .res_mask (res_mask),
        .done     (done),
        .blk_cnt  (blk_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int mode  = 0;

    function automatic logic fmask(input logic [IDX_W-1:0] idx, input int md);
        case (md)
            0:       return idx[0];
            1:       return 1'b1;
            2:       return idx[1];
            default: return 1'b0;
        endcase
    endfunction

    function automatic int exp_blk(input int n);
`ifdef PRM_BLK_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    // Checker bank model: CHK_LAT-cycle delay from chk_valid to chk_mask.
    logic [1:0]       m_v = 2'b00;
    logic [IDX_W-1:0] m_idx0 = '0;
    logic [IDX_W-1:0] m_idx1 = '0;
    always @(posedge clk) begin
        m_v[0] <= chk_valid;
        m_idx0 <= chk_idx;
        m_v[1] <= m_v[0];
        m_idx1 <= m_idx0;
    end
    assign chk_mask = m_v[1] ? fmask(m_idx1, mode) : 1'b0;

    logic [IDX_W:0] q[$];
    int             exp_idx;
    logic [14:0]    exp_obs;
    int             n_issue;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec = n_vec + 1;
        assert (obs === expv) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: compare a transfer about to happen, step the edge, record issues.
    task automatic tick();
        logic [IDX_W:0] e;
        if (res_valid && res_ready) begin
            if (q.size() == 0) begin
                check("res_unexpected", 32'(res_idx) + 32'd100, 32'd0);
            end else begin
                e = q.pop_front();
                check("res_idx", 32'(res_idx), 32'(e[IDX_W:1]));
                check("res_mask", 32'(res_mask), 32'(e[0]));
            end
        end
        @(posedge clk);
        #1;
        if (chk_valid) begin
            check("chk_idx", 32'(chk_idx), 32'(exp_idx));
            check("chk_obs", 32'(chk_obs), 32'(exp_obs));
            q.push_back({IDX_W'(exp_idx), fmask(IDX_W'(exp_idx), mode)});
            exp_idx = exp_idx + 1;
            n_issue = n_issue + 1;
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
        check({pfx, "_chk_valid"}, 32'(chk_valid), 32'd0);
        check({pfx, "_chk_idx"},   32'(chk_idx),   32'd0);
        check({pfx, "_chk_obs"},   32'(chk_obs),   32'd0);
        check({pfx, "_res_valid"}, 32'(res_valid), 32'd0);
        check({pfx, "_res_idx"},   32'(res_idx),   32'd0);
        check({pfx, "_res_mask"},  32'(res_mask),  32'd0);
        check({pfx, "_done"},      32'(done),      32'd0);
        check({pfx, "_blk_cnt"},   32'(blk_cnt),   32'd0);
    endtask

    // Accept a request with the given vector and run until done or budget.
    task automatic run_scan(input logic [14:0] obs, output int donec, output int firstc);
        int c;
        req_obs   = obs;
        exp_obs   = obs;
        exp_idx   = 0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_issue   = 0;
        c         = 0;
        donec     = -1;
        firstc    = -1;
        while (c < 60 && donec < 0) begin
            if (c == 3) begin
                req_valid = 1'b1;
                req_obs   = 15'h7FFF;
                check("busy_req_ready", 32'(req_ready), 32'd0);
            end else begin
                req_valid = 1'b0;
            end
            tick();
            c = c + 1;
            if (chk_valid && firstc < 0) firstc = c;
            if (done) donec = c;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        int donec;
        int firstc;
        int c;
        int prev_blk;
        logic saw_res;
        logic saw_done;

        rst = 1'b1; req_valid = 1'b0; req_obs = 15'd0; abort = 1'b0;
        res_ready = 1'b0; exp_idx = 0; exp_obs = 15'd0; n_issue = 0;
        tick();
        tick();
        check_reset_vals("rst");
        rst = 1'b0;
        tick();
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // Basic sweep at full rate
        mode      = 0;
        res_ready = 1'b1;
        run_scan(15'h4A31, donec, firstc);
        check("basic_first_issue", 32'(firstc), 32'd1);
        check("basic_done_cycle", 32'(donec), 32'd13);
        check("basic_issued", 32'(exp_idx), 32'(NUM_EDGES));
        check("basic_queue_empty", 32'(q.size()), 32'd0);
        check("basic_blk_cnt", 32'(blk_cnt), 32'(exp_blk(4)));
        check("basic_chk_obs", 32'(chk_obs), 32'h4A31);
        tick();
        check("basic_done_one_cycle", 32'(done), 32'd0);
        check("basic_back_idle", 32'(req_ready), 32'd1);

        // Backpressure: consumer stalled from the start
        mode      = 2;
        res_ready = 1'b0;
        req_obs   = 15'h1234;
        exp_obs   = 15'h1234;
        exp_idx   = 0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_issue   = 0;
        repeat (12) tick();
        check("bp_issue_count", 32'(n_issue), 32'(FIFO_DEPTH));
        check("bp_chk_valid_low", 32'(chk_valid), 32'd0);
        check("bp_res_valid", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        c = 0;
        donec = -1;
        while (c < 60 && donec < 0) begin
            tick();
            c = c + 1;
            if (done) donec = c;
        end
        check("bp_done_seen", 32'(donec > 0), 32'd1);
        check("bp_issued", 32'(exp_idx), 32'(NUM_EDGES));
        check("bp_queue_empty", 32'(q.size()), 32'd0);
        check("bp_blk_cnt", 32'(blk_cnt), 32'(exp_blk(4)));
        prev_blk = exp_blk(4);
        tick();

        // Abort at the second issue
        mode      = 1;
        req_obs   = 15'h0F0F;
        exp_obs   = 15'h0F0F;
        exp_idx   = 0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_issue   = 0;
        c = 0;
        while (n_issue < 2 && c < 10) begin
            tick();
            c = c + 1;
        end
        check("abort_at_second", 32'(n_issue), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        q.delete();
        check("abort_idle", 32'(req_ready), 32'd1);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_chk_valid", 32'(chk_valid), 32'd0);
        saw_res  = 1'b0;
        saw_done = 1'b0;
        repeat (8) begin
            tick();
            saw_res  = saw_res | res_valid;
            saw_done = saw_done | done;
        end
        check("abort_no_result", 32'(saw_res), 32'd0);
        check("abort_no_done", 32'(saw_done), 32'd0);
        check("abort_blk_kept", 32'(blk_cnt), 32'(prev_blk));
        run_scan(15'h0F0F, donec, firstc);
        check("rescan_done_cycle", 32'(donec), 32'd13);
        check("rescan_issued", 32'(exp_idx), 32'(NUM_EDGES));
        check("rescan_blk_all_ones", 32'(blk_cnt), 32'(exp_blk(8)));
        tick();

        // Reset during DRAIN
        mode      = 0;
        req_obs   = 15'h5555;
        exp_obs   = 15'h5555;
        exp_idx   = 0;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n_issue   = 0;
        c = 0;
        while (n_issue < NUM_EDGES && c < 30) begin
            tick();
            c = c + 1;
        end
        check("drain_reached", 32'(n_issue), 32'(NUM_EDGES));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        check_reset_vals("mid_drain");
        saw_res  = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            tick();
            saw_res  = saw_res | res_valid;
            saw_done = saw_done | done;
        end
        check("late_mask_dropped", 32'(saw_res), 32'd0);
        check("rst_no_done", 32'(saw_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
